// File: rtl/alu_arbiter_pkg.sv
// Shared ISA funct encodings and datapath widths for the ALU arbiter slice.
package alu_arbiter_pkg;
  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUN_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUN_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] FUN_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] FUN_SLLV = 6'b000100;
  localparam logic [FUNCT_W-1:0] FUN_SRLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] FUN_SRAV = 6'b000111;
  localparam logic [FUNCT_W-1:0] FUN_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUN_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] FUN_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUN_SUBU = 6'b100011;
  localparam logic [FUNCT_W-1:0] FUN_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUN_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUN_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FUN_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUN_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUN_SLTU = 6'b101011;
endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU; unknown funct codes produce 0. Shifts move opA by opB[4:0].
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  opA,
  input  logic [DATA_W-1:0]  opB,
  input  logic [FUNCT_W-1:0] funct,
  output logic [DATA_W-1:0]  out,
  output logic               zero
);
  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic        [4:0]        shamt;

  assign sa    = opA;
  assign sb    = opB;
  assign shamt = opB[4:0];

  always_comb begin
    out = '0;
    case (funct)
      FUN_ADD, FUN_ADDU: out = opA + opB;
      FUN_SUB, FUN_SUBU: out = opA - opB;
      FUN_AND:           out = opA & opB;
      FUN_OR:            out = opA | opB;
      FUN_XOR:           out = opA ^ opB;
      FUN_NOR:           out = ~(opA | opB);
      FUN_SLT:           out = {{(DATA_W-1){1'b0}}, (sa < sb)};
      FUN_SLTU:          out = {{(DATA_W-1){1'b0}}, (opA < opB)};
      FUN_SLL, FUN_SLLV: out = opA << shamt;
      FUN_SRL, FUN_SRLV: out = opA >> shamt;
      FUN_SRA, FUN_SRAV: out = sa >>> shamt;
      default:           out = '0;
    endcase
  end

  assign zero = (out == '0);
endmodule

// File: rtl/alu_rr_grant.sv
// Two-way round-robin grant; the pointer flips to the other side after any grant.
module alu_rr_grant (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic ptr;

  assign grant[0] = valid[0] & (~valid[1] | ~ptr);
  assign grant[1] = valid[1] & (~valid[0] |  ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ptr <= 1'b0;
    else if (grant[0]) ptr <= 1'b1;
    else if (grant[1]) ptr <= 1'b0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the EX datapath (port 0) and the aux unit (port 1),
// returning a registered result one cycle after the grant.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_opA,
  input  logic [DATA_W-1:0]  req0_opB,
  input  logic [FUNCT_W-1:0] req0_funct,
  output logic               resp0_valid,
  output logic [DATA_W-1:0]  resp0_out,
  output logic               resp0_zero,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_opA,
  input  logic [DATA_W-1:0]  req1_opB,
  input  logic [FUNCT_W-1:0] req1_funct,
  output logic               resp1_valid,
  output logic [DATA_W-1:0]  resp1_out,
  output logic               resp1_zero,
  output logic [CNT_W-1:0]   conflict_cnt
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]         grant;
  logic [DATA_W-1:0]  opa_p0;
  logic [DATA_W-1:0]  opb_p0;
  logic [FUNCT_W-1:0] funct_p0;
  logic [DATA_W-1:0]  alu_out_p0;
  logic               alu_zero_p0;

  logic               vld0_p1;
  logic               vld1_p1;
  logic [DATA_W-1:0]  out0_p1;
  logic [DATA_W-1:0]  out1_p1;
  logic               zero0_p1;
  logic               zero1_p1;
  logic [CNT_W-1:0]   cnt_q;

  alu_rr_grant u_grant (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // p0: operand select and ALU evaluation for the granted requester
  assign opa_p0   = grant[1] ? req1_opA   : req0_opA;
  assign opb_p0   = grant[1] ? req1_opB   : req0_opB;
  assign funct_p0 = grant[1] ? req1_funct : req0_funct;

  alu_arbiter_alu u_alu (
    .opA   (opa_p0),
    .opB   (opb_p0),
    .funct (funct_p0),
    .out   (alu_out_p0),
    .zero  (alu_zero_p0)
  );

  // p1: per-port result registers; only the granted port updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld0_p1  <= 1'b0;
      vld1_p1  <= 1'b0;
      out0_p1  <= '0;
      out1_p1  <= '0;
      zero0_p1 <= 1'b0;
      zero1_p1 <= 1'b0;
    end else begin
      vld0_p1 <= grant[0];
      vld1_p1 <= grant[1];
      if (grant[0]) begin
        out0_p1  <= alu_out_p0;
        zero0_p1 <= alu_zero_p0;
      end
      if (grant[1]) begin
        out1_p1  <= alu_out_p0;
        zero1_p1 <= alu_zero_p0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt_q <= '0;
    else if (req0_valid && req1_valid) cnt_q <= sat_inc(cnt_q);
  end

  assign resp0_valid  = vld0_p1;
  assign resp0_out    = out0_p1;
  assign resp0_zero   = zero0_p1;
  assign resp1_valid  = vld1_p1;
  assign resp1_out    = out1_p1;
  assign resp1_zero   = zero1_p1;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_opA, req0_opB, req1_opA, req1_opB;
  logic [5:0]  req0_funct, req1_funct;
  logic        resp0_valid, resp1_valid, resp0_zero, resp1_zero;
  logic [31:0] resp0_out, resp1_out;
  logic [CW-1:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  // model state
  int          ptr;
  int          cnt;
  int          last_g;
  logic [31:0] e_out0, e_out1;
  logic        e_z0, e_z1;

  logic [5:0] codes [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opA(req0_opA),
    .req0_opB(req0_opB), .req0_funct(req0_funct),
    .resp0_valid(resp0_valid), .resp0_out(resp0_out), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opA(req1_opA),
    .req1_opB(req1_opB), .req1_funct(req1_funct),
    .resp1_valid(resp1_valid), .resp1_out(resp1_out), .resp1_zero(resp1_zero),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f);
    int unsigned s;
    s = b % 32;
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2a: return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
      6'h2b: return (a < b) ? 32'd1 : 32'd0;
      6'h00, 6'h04: return a * (32'd1 << s);
      6'h02, 6'h06: return a / (32'd1 << s);
      6'h03, 6'h07: return (a / (32'd1 << s)) | (a[31] ? ~(32'hffffffff >> s) : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr = 0; cnt = 0; last_g = -1;
    e_out0 = '0; e_out1 = '0; e_z0 = 1'b0; e_z1 = 1'b0;
  endtask

  task automatic check_idle_outputs();
    check("rst_v0", 32'(resp0_valid), 0);
    check("rst_v1", 32'(resp1_valid), 0);
    check("rst_out0", resp0_out, 0);
    check("rst_out1", resp1_out, 0);
    check("rst_z0", 32'(resp0_zero), 0);
    check("rst_z1", 32'(resp1_zero), 0);
    check("rst_cnt", 32'(conflict_cnt), 0);
  endtask

  // Called with inputs already driven, away from the clock edge.
  task automatic step();
    int g;
    #1;
    if (req0_valid && req1_valid) g = ptr;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    else                          g = -1;
    check("ready0", 32'(req0_ready), 32'(g == 0));
    check("ready1", 32'(req1_ready), 32'(g == 1));
    if (g == 0) begin
      e_out0 = ref_alu(req0_opA, req0_opB, req0_funct);
      e_z0   = (e_out0 == 0);
    end
    if (g == 1) begin
      e_out1 = ref_alu(req1_opA, req1_opB, req1_funct);
      e_z1   = (e_out1 == 0);
    end
    if (req0_valid && req1_valid && cnt < CNT_MAX) cnt++;
    if (g >= 0) ptr = 1 - g;
    last_g = g;
    @(posedge clk);
    #1;
    check("resp0_valid", 32'(resp0_valid), 32'(g == 0));
    check("resp1_valid", 32'(resp1_valid), 32'(g == 1));
    check("resp0_out", resp0_out, e_out0);
    check("resp0_zero", 32'(resp0_zero), 32'(e_z0));
    check("resp1_out", resp1_out, e_out1);
    check("resp1_zero", 32'(resp1_zero), 32'(e_z1));
    check("conflict_cnt", 32'(conflict_cnt), 32'(cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_idle_outputs();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_opA = 0; req0_opB = 0; req0_funct = 0;
    req1_opA = 0; req1_opB = 0; req1_funct = 0;
    model_reset();
    @(posedge clk); #1;
    check_idle_outputs();
    reset = 1'b0;

    // single requester ADD 5+7
    req0_valid = 1; req0_opA = 5; req0_opB = 7; req0_funct = 6'b100000;
    step();
    check("add_result", resp0_out, 32'd12);
    req0_valid = 0;
    step();

    // reset while an op is being accepted
    req0_valid = 1; req0_opA = 5; req0_opB = 7; req0_funct = 6'b100000;
    req1_valid = 1; req1_opA = 3; req1_opB = 3; req1_funct = 6'b100100;
    step();
    req1_valid = 0;
    req0_opA = 1; req0_opB = 2;
    #1;
    check("midrst_ready0", 32'(req0_ready), 1);
    reset = 1'b1;
    #1;
    check_idle_outputs();
    @(posedge clk); #1;
    check("midrst_no_resp", 32'(resp0_valid), 0);
    reset = 1'b0;
    model_reset();
    req0_valid = 0;
    step();

    // contention: SUB 9-9 vs SLT -1,1
    req0_valid = 1; req0_opA = 9; req0_opB = 9; req0_funct = 6'b100010;
    req1_valid = 1; req1_opA = 32'hffffffff; req1_opB = 1; req1_funct = 6'b101010;
    step();
    check("cont_zero", 32'(resp0_zero), 1);
    req0_valid = 0;
    step();
    check("cont_slt", resp1_out, 32'd1);
    check("cont_cnt", 32'(conflict_cnt), 32'd1);
    req1_valid = 0;

    // pointer after an uncontested grant to requester 1
    do_reset();
    req1_valid = 1; req1_opA = 4; req1_opB = 1; req1_funct = 6'b000000;
    step();
    req0_valid = 1; req0_opA = 32'h80000000; req0_opB = 4; req0_funct = 6'b000011;
    req1_opA = 6; req1_opB = 2;
    step();
    check("ptr_after_solo", 32'(last_g), 0);
    step();
    req0_valid = 0; req1_valid = 0;

    // fairness with distinct AND operands; loser holds its request
    do_reset();
    begin
      int n0, n1;
      n0 = 0; n1 = 0;
      req0_funct = 6'b100100; req1_funct = 6'b100100;
      req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 6; i++) begin
        req0_opA = 32'hf0f0_0000 | n0; req0_opB = 32'hffff_00ff;
        req1_opA = 32'h0f0f_0000 | n1; req1_opB = 32'h00ff_ffff;
        step();
        check("fair_alt", 32'(last_g), 32'(i % 2));
        if (last_g == 0) n0++;
        if (last_g == 1) n1++;
      end
    end

    // saturation: continuous contention for 20 cycles
    do_reset();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 20; i++) begin
      req0_opA = $urandom; req0_opB = $urandom; req0_funct = 6'b100001;
      req1_opA = $urandom; req1_opB = $urandom; req1_funct = 6'b100110;
      step();
    end
    check("sat_hold", 32'(conflict_cnt), 32'(CNT_MAX));

    // randomized traffic respecting the hold-until-ready rule
    do_reset();
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 300; i++) begin
      bit pend0, pend1;
      pend0 = req0_valid && (last_g != 0);
      pend1 = req1_valid && (last_g != 1);
      if (i == 150) do_reset();
      if (!pend0 || $urandom_range(0, 7) == 0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_opA   = $urandom;
        req0_opB   = ($urandom_range(0, 3) == 0) ? req0_opA : $urandom;
        req0_funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 15)];
      end
      if (!pend1 || $urandom_range(0, 7) == 0) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_opA   = $urandom;
        req1_opB   = ($urandom_range(0, 3) == 0) ? req1_opA : $urandom;
        req1_funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 15)];
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational Alu instance between two requesters: port 0 is the EX-stage datapath and port 1 is the auxiliary address/compare unit.
- Uses round-robin arbitration with a valid/ready request handshake.
- Returns a registered result, with a 1-cycle latency, to the granted requester only.
- Keeps a saturating contention counter for performance debug.

Parameters:
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 granted this cycle
- req0_opA  in  32  operand A
- req0_opB  in  32  operand B (shift amount for shifts)
- req0_funct  in  6  ALU function code (ISA funct encoding)
- resp0_valid  out  1  result for requester 0 is valid
- resp0_out  out  32  result
- resp0_zero  out  1  result == 0
- req1_valid, req1_ready, req1_opA, req1_opB, req1_funct  same as the req0 ports, for requester 1
- resp1_valid, resp1_out, resp1_zero  same as the resp0 ports, for requester 1
- conflict_cnt  out  CNT_W  cycles in which both requesters were valid (saturating)

Behaviour:
- Reset (async, immediate):
  - resp0_valid = resp1_valid = 0; resp*_out = 0; resp*_zero = 0.
  - Priority pointer = 0 (requester 0 favoured); conflict_cnt = 0.
  - Any in-flight result is discarded and no response is produced for it.
- Handshake:
  - A transfer occurs when reqN_valid && reqN_ready in the same cycle.
  - reqN_ready is combinational from the valid inputs and the pointer. It never depends on the responses.
  - A requester holds valid, opA, opB and funct stable until ready. Valid may be deasserted without a transfer (no penalty).
- Grant rules:
  - Exactly one grant per cycle at most.
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant the requester the pointer names.
  - The pointer moves to the other requester after every grant (including uncontested grants). It is unchanged when there is no grant.
- Datapath:
  - Mux the granted operands and funct into the Alu.
  - On the clock edge, register Alu out/zero into the granted port's resp registers and pulse that port's resp_valid for exactly one cycle.
  - The non-granted port's resp_valid = 0. Its resp_out/zero hold their previous value.
- Latency and throughput:
  - Request accepted in cycle T -> response in cycle T+1.
  - Throughput is 1 op/cycle in total.
  - There is no response backpressure; the requester must sample in the valid cycle.
- Unrecognised funct: passes through; the Alu yields 0, so zero = 1. The arbiter raises no error.
- Width rules: shifts use opB as supplied; the requester places shamt/rs in opB.
- conflict_cnt: +1 in each cycle with req0_valid && req1_valid. It holds at all-ones once saturated and never wraps.
- Fairness:
  - Under continuous dual requests, grants alternate 0,1,0,1...
  - Neither requester waits more than 1 cycle while valid.

Decomposition:
- Funct code constants (FUN_ADD, FUN_SUB, FUN_SLT, ...) come from the shared ISA include; no new constants are added.
- Sub-module alu_rr_grant: 2-way round-robin grant logic plus the pointer flop (inputs clk, reset, valid[1:0]; outputs grant[1:0]).
- The top level holds the operand mux, the Alu instance, the response registers and the counter.

Test Plan:
- Reset mid-op: req0 ADD (funct 100000) 5+7 accepted, reset asserted before the next edge -> no resp0_valid; all outputs 0 immediately; conflict_cnt 0.
- Single requester: req0 ADD opA=5, opB=7 -> req0_ready=1 same cycle; next cycle resp0_valid=1, resp0_out=12, resp0_zero=0; resp1_valid=0.
- Contention: after reset both valid, req0 SUB (100010) 9-9, req1 SLT (101010) -1 vs 1 ->
  - cycle T: grant 0.
  - T+1: resp0_out=0, zero=1; grant 1.
  - T+2: resp1_out=1.
  - conflict_cnt=1.
- Fairness: both valid for 6 cycles with distinct AND (100100) operands -> grant sequence 0,1,0,1,0,1; each resp matches its own operands; conflict_cnt tracks contended cycles.
- Pointer after uncontested grant: req1 alone granted, then both valid -> req0 granted first.
- Saturation: CNT_W=4, both valid 20 cycles -> conflict_cnt reaches 15 and holds at 15.
